// File: rtl/stream_decryptor_pkg.sv
// Shared types and constants for the stream decryptor.
// Inverse S-box table, FSM state and default LFSR taps.
package stream_decryptor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8,
        4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3,
        4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [3:0] inv_sbox(
        input logic [3:0] c
    );
        return INV_SBOX[c];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a zero-when-empty head output.
// Clear wins over push and pop in the same cycle.
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            cnt  <= cnt + (AW+1)'(do_push)
                        - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/stream_decryptor.sv
// Streaming nibble decryptor: inverse S-box then LFSR keystream XOR.
// Plaintext is queued in an output FIFO behind valid/ready.
module stream_decryptor
    import stream_decryptor_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 4,
    localparam int DW     = 4*NIBBLES,
    parameter logic [DW-1:0] TAPS = DW'(DEFAULT_TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_load,
    input  logic [DW-1:0] key_seed,
    input  logic          bypass,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [15:0]   word_cnt,
    output logic          key_err
);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] lfsr;
    logic [DW-1:0] lfsr_step;
    logic [DW-1:0] plain;
    logic          seed_ok;
    logic          acc;
    logic          full;
    logic          empty;

    assign seed_ok   = key_load && (|key_seed);
    assign acc       = in_valid && in_ready && !flush;
    assign out_valid = !empty;
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS)
                               : (lfsr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            flush:   state_nxt = IDLE;
            seed_ok: state_nxt = RUN;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN) && !full;
    end

    for (genvar g = 0; g < NIBBLES; g++) begin : g_lane
        assign plain[4*g +: 4] = bypass
            ? in_data[4*g +: 4]
            : inv_sbox(in_data[4*g +: 4]) ^ lfsr[4*g +: 4];
    end

    // A load in the same cycle as an accept wins over the advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= '0;
        else if (seed_ok && !flush)
            lfsr <= key_seed;
        else if (acc && !bypass)
            lfsr <= lfsr_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            key_err <= 1'b0;
        else if (key_load && !flush)
            key_err <= ~|key_seed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_cnt <= '0;
        else if (out_valid && out_ready)
            word_cnt <= word_cnt + 16'd1;
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (acc),
        .wdata (plain),
        .pop   (out_ready),
        .full  (full),
        .empty (empty),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_stream_decryptor.sv
// Bench for stream_decryptor: queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_stream_decryptor;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load = 1'b0;
    logic [15:0] key_seed = '0;
    logic        bypass = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] word_cnt;
    logic        key_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_decryptor #(
        .NIBBLES (4),
        .DEPTH   (DEPTH),
        .TAPS    (16'hB400)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_seed  (key_seed),
        .bypass    (bypass),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt),
        .key_err   (key_err)
    );

    localparam logic [3:0] INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    logic [15:0] mq[$];
    logic [15:0] mkey = '0;
    logic        mrun = 1'b0;
    logic        merr = 1'b0;
    logic [15:0] mcnt = '0;
    bit          m_pop;
    bit          m_acc;

    function automatic logic [15:0] dec(
        input logic [15:0] c,
        input logic [15:0] k,
        input logic        b
    );
        logic [15:0] p;
        if (b) return c;
        for (int i = 0; i < 4; i++)
            p[4*i +: 4] = INV[c[4*i +: 4]] ^ k[4*i +: 4];
        return p;
    endfunction

    function automatic logic [15:0] next_key(
        input logic [15:0] k
    );
        return k[0] ? ((k >> 1) ^ 16'hB400) : (k >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mkey = '0;
            mrun = 1'b0;
            merr = 1'b0;
            mcnt = '0;
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            m_acc = in_valid && mrun
                 && (mq.size() < DEPTH) && !flush;
            if (m_pop) mcnt = mcnt + 16'd1;
            if (flush) begin
                mq.delete();
                mrun = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) mq.push_back(dec(in_data, mkey, bypass));
                if (m_acc && !bypass) mkey = next_key(mkey);
                if (key_load) begin
                    if (key_seed == 16'h0) begin
                        merr = 1'b1;
                    end else begin
                        mkey = key_seed;
                        merr = 1'b0;
                        mrun = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string n,
                       input logic [15:0] a,
                       input logic [15:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     n, a, e, $time);
        end
    endtask

    task automatic chk1(input string n,
                        input logic a,
                        input logic e);
        chk(n, {15'b0, a}, {15'b0, e});
    endtask

    always @(negedge clk) begin
        chk1("out_valid", out_valid, mq.size() > 0);
        chk("out_data", out_data,
            (mq.size() > 0) ? mq[0] : 16'h0);
        chk1("in_ready", in_ready,
             mrun && (mq.size() < DEPTH));
        chk("word_cnt", word_cnt, mcnt);
        chk1("key_err", key_err, merr);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] cnt_before;

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        in_valid = 1'b1;
        tick();
        tick();
        chk1("t1_in_ready", in_ready, 1'b0);
        chk1("t1_out_valid", out_valid, 1'b0);
        chk("t1_word_cnt", word_cnt, 16'h0);
        in_valid = 1'b0;

        key_seed = 16'h0001;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        in_data  = 16'h0000;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t2_first", out_data, 16'h5554);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_second", out_data, 16'hE155);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("t2_drained", out_valid, 1'b0);

        bypass   = 1'b1;
        in_data  = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bypass   = 1'b0;
        chk("t3_bypass", out_data, 16'h1234);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0000;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_same_key", out_data, 16'h0F55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 16'(i * 16'h1111);
            tick();
        end
        chk1("t4_full", in_ready, 1'b0);
        tick();
        chk1("t4_still_full", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("t4_room", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        key_seed = 16'h0000;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk1("t5_key_err", key_err, 1'b1);
        chk1("t5_idle", in_ready, 1'b0);
        key_seed = 16'h0001;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk1("t5_err_clr", key_err, 1'b0);
        chk1("t5_run", in_ready, 1'b1);

        for (int i = 0; i < 40; i++) begin
            in_valid  = (i % 3) != 0;
            out_ready = (i % 4) != 1;
            bypass    = (i % 5) == 2;
            in_data   = 16'(i * 4951);
            key_load  = (i == 20);
            key_seed  = 16'hACE1;
            tick();
        end
        in_valid  = 1'b0;
        bypass    = 1'b0;
        key_load  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;

        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (3) tick();
        in_valid = 1'b0;
        chk1("t6_queued", out_valid, 1'b1);
        cnt_before = mcnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("t6_flush_valid", out_valid, 1'b0);
        chk1("t6_flush_idle", in_ready, 1'b0);
        chk("t6_cnt_kept", word_cnt, cnt_before);

        key_seed = 16'h0001;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_in_ready", in_ready, 1'b0);
        chk1("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_out_data", out_data, 16'h0);
        chk("t6_rst_word_cnt", word_cnt, 16'h0);
        chk1("t6_rst_key_err", key_err, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
